// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the shared RAM port: CPU on port 0, auxiliary master on port 1.
// Serialises accesses, sequences the fixed RAM read latency and returns one-cycle ready pulses.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int RAM_LATENCY  = 2,
  parameter int CPU_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset_cycle,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ready,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_AUX  = 2'b10;

  localparam logic [3:0] LAST_CNT = 4'(RAM_LATENCY - 1);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [3:0]        cnt_r;
  logic [1:0]        grant_r;
  logic              last_aux_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              ram_en_r;
  logic              ram_we_r;
  logic              cpu_ready_r;
  logic              aux_ready_r;
  logic [DATA_W-1:0] cpu_rdata_r;
  logic [DATA_W-1:0] aux_rdata_r;
  logic [1:0]        win_s;
  logic              start_s;

  function automatic logic [1:0] pick_winner(input logic cpu_rq, input logic aux_rq,
                                             input logic last_aux);
    logic [1:0] w;
    if (cpu_rq && aux_rq) begin
      if (CPU_PRIORITY == 1) begin
        w = GRANT_CPU;
      end else if (last_aux) begin
        w = GRANT_CPU;
      end else begin
        w = GRANT_AUX;
      end
    end else if (cpu_rq) begin
      w = GRANT_CPU;
    end else if (aux_rq) begin
      w = GRANT_AUX;
    end else begin
      w = GRANT_NONE;
    end
    return w;
  endfunction

  // Arbitration in IDLE and next-state decode
  always_comb begin
    win_s       = GRANT_NONE;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        win_s = pick_winner(cpu_req, aux_req, last_aux_r);
        if (win_s != GRANT_NONE) begin
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = CAPTURE;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      CAPTURE: state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  assign start_s = (state_r == IDLE) && (win_s != GRANT_NONE);

  // State register and latency counter
  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if (start_s) begin
        cnt_r <= 4'd0;
      end else if (state_r == ACCESS) begin
        cnt_r <= cnt_r + 4'd1;
      end
    end
  end

  // Winner's request is latched once and held for the whole transaction
  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      grant_r    <= GRANT_NONE;
      last_aux_r <= 1'b1;
      we_r       <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
    end else if (start_s) begin
      grant_r    <= win_s;
      last_aux_r <= win_s[1];
      we_r       <= win_s[1] ? aux_we    : cpu_we;
      addr_r     <= win_s[1] ? aux_addr  : cpu_addr;
      wdata_r    <= win_s[1] ? aux_wdata : cpu_wdata;
    end else if (state_r == RESP) begin
      grant_r <= GRANT_NONE;
    end
  end

  // RAM strobes fire only in the first ACCESS cycle
  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      ram_en_r <= 1'b0;
      ram_we_r <= 1'b0;
    end else begin
      ram_en_r <= start_s;
      ram_we_r <= start_s && (win_s[1] ? aux_we : cpu_we);
    end
  end

  // Read data capture and completion pulses
  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      cpu_ready_r <= 1'b0;
      aux_ready_r <= 1'b0;
      cpu_rdata_r <= {DATA_W{1'b0}};
      aux_rdata_r <= {DATA_W{1'b0}};
    end else begin
      cpu_ready_r <= (state_r == CAPTURE) && grant_r[0];
      aux_ready_r <= (state_r == CAPTURE) && grant_r[1];
      if ((state_r == CAPTURE) && !we_r) begin
        if (grant_r[0]) begin
          cpu_rdata_r <= ram_rdata;
        end else if (grant_r[1]) begin
          aux_rdata_r <= ram_rdata;
        end
      end
    end
  end

  assign cpu_ready = cpu_ready_r;
  assign aux_ready = aux_ready_r;
  assign cpu_rdata = cpu_rdata_r;
  assign aux_rdata = aux_rdata_r;
  assign ram_en    = ram_en_r;
  assign ram_we    = ram_we_r;
  assign ram_addr  = addr_r;
  assign ram_wdata = wdata_r;
  assign grant     = grant_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: four configurations share one stimulus stream, each checked every
// cycle against a transaction-timing model, plus directed literal expectations.
module tb_mem_bus_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_cycle;
  logic       cpu_req, cpu_we, aux_req, aux_we;
  logic [7:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic [N-1:0]      cpu_ready_w, aux_ready_w, ram_en_w, ram_we_w, busy_w;
  logic [N-1:0][7:0] cpu_rdata_w, aux_rdata_w, ram_addr_w, ram_wdata_w, ram_rdata_w;
  logic [N-1:0][1:0] grant_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: L=2 round-robin, 1: L=2 cpu priority, 2: L=1, 3: L=15
  function automatic int lat_of(input int i);
    case (i)
      0, 1:    return 2;
      2:       return 1;
      default: return 15;
    endcase
  endfunction
  function automatic int pri_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction
  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'h5A : (a ^ 8'h3C);
  endfunction

  for (genvar g = 0; g < N; g = g + 1) begin : g_dut
    logic [7:0]   mem [256];
    logic [255:0] wflag = '0;
    logic [7:0]   paddr = 8'h00;
    int           dcnt = 0;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LATENCY(lat_of(g)), .CPU_PRIORITY(pri_of(g))) u_dut (
      .clk(clk), .reset_cycle(reset_cycle),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready_w[g]), .cpu_rdata(cpu_rdata_w[g]),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_ready(aux_ready_w[g]), .aux_rdata(aux_rdata_w[g]),
      .ram_en(ram_en_w[g]), .ram_we(ram_we_w[g]), .ram_addr(ram_addr_w[g]),
      .ram_wdata(ram_wdata_w[g]), .ram_rdata(ram_rdata_w[g]),
      .grant(grant_w[g]), .busy(busy_w[g])
    );

    // RAM model: read data valid only RAM_LATENCY cycles after ram_en, garbage otherwise
    always @(posedge clk) begin
      if (ram_en_w[g] && ram_we_w[g]) begin
        mem[ram_addr_w[g]]   <= ram_wdata_w[g];
        wflag[ram_addr_w[g]] <= 1'b1;
      end
      if (ram_en_w[g] && !ram_we_w[g]) begin
        paddr <= ram_addr_w[g];
        dcnt  <= lat_of(g);
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
      end
    end
    assign ram_rdata_w[g] = (dcnt == 1) ? (wflag[paddr] ? mem[paddr] : init_val(paddr)) : 8'hEE;
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  // Transaction-level model: a win at cycle s means ram_en at s+1, ready at s+L+2, idle at s+L+3
  int           m_start [N];
  int           m_free  [N];
  logic [1:0]   m_own   [N];
  logic         m_last_aux [N];
  logic         m_we    [N];
  logic [7:0]   m_addr  [N];
  logic [7:0]   m_wdata [N];
  logic [7:0]   m_crd   [N];
  logic [7:0]   m_ard   [N];
  logic [7:0]   m_mem   [N][256];
  logic [255:0] m_wflag [N];

  task automatic model_step(input int i);
    int lat;
    int d;
    bit act;
    logic [1:0] w;
    logic [7:0] rd;
    lat = lat_of(i);
    act = 1'b0;
    d   = 0;
    if (reset_cycle) begin
      m_free[i] = 0; m_own[i] = 2'b00; m_last_aux[i] = 1'b1; m_we[i] = 1'b0;
      m_addr[i] = 8'h00; m_wdata[i] = 8'h00; m_crd[i] = 8'h00; m_ard[i] = 8'h00;
    end else begin
      act = (m_own[i] != 2'b00) && (cyc < m_free[i]);
      d   = cyc - m_start[i];
      if (act && d == 1 && m_we[i]) begin
        m_mem[i][m_addr[i]]   = m_wdata[i];
        m_wflag[i][m_addr[i]] = 1'b1;
      end
      if (act && d == lat + 2 && !m_we[i]) begin
        rd = m_wflag[i][m_addr[i]] ? m_mem[i][m_addr[i]] : init_val(m_addr[i]);
        if (m_own[i][0]) m_crd[i] = rd;
        else m_ard[i] = rd;
      end
    end
    chk("busy", i, 32'(busy_w[i]), 32'(act));
    chk("grant", i, 32'(grant_w[i]), act ? 32'(m_own[i]) : 32'd0);
    chk("ram_en", i, 32'(ram_en_w[i]), 32'(act && d == 1));
    chk("ram_we", i, 32'(ram_we_w[i]), 32'(act && d == 1 && m_we[i]));
    if (act && d <= lat + 1) begin
      chk("ram_addr", i, 32'(ram_addr_w[i]), 32'(m_addr[i]));
      chk("ram_wdata", i, 32'(ram_wdata_w[i]), 32'(m_wdata[i]));
    end
    chk("cpu_ready", i, 32'(cpu_ready_w[i]), 32'(act && d == lat + 2 && m_own[i][0]));
    chk("aux_ready", i, 32'(aux_ready_w[i]), 32'(act && d == lat + 2 && m_own[i][1]));
    chk("cpu_rdata", i, 32'(cpu_rdata_w[i]), 32'(m_crd[i]));
    chk("aux_rdata", i, 32'(aux_rdata_w[i]), 32'(m_ard[i]));
    if (!reset_cycle && !act) begin
      m_own[i] = 2'b00;
      if (cpu_req && (!aux_req || pri_of(i) == 1 || m_last_aux[i])) w = 2'b01;
      else if (aux_req) w = 2'b10;
      else w = 2'b00;
      if (w != 2'b00) begin
        m_own[i] = w; m_start[i] = cyc; m_free[i] = cyc + lat + 3; m_last_aux[i] = w[1];
        m_we[i]    = w[1] ? aux_we    : cpu_we;
        m_addr[i]  = w[1] ? aux_addr  : cpu_addr;
        m_wdata[i] = w[1] ? aux_wdata : cpu_wdata;
      end
    end
  endtask

  // Compare process: every instance, every cycle, away from the active edge
  initial begin
    for (int i = 0; i < N; i++) m_wflag[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) model_step(i);
    end
  end

  task automatic access_on(input int tgt, input bit aux, input bit we, input logic [7:0] addr,
                           input logic [7:0] wd, output int lat);
    if (aux) begin
      aux_req = 1'b1; aux_we = we; aux_addr = addr; aux_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((aux ? aux_ready_w[tgt] : cpu_ready_w[tgt]) == 1'b1) begin
        lat = n;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    aux_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_w !== '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_wait busy=%b required 0", busy_w);
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset_cycle = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_cycle = 1'b0;
  endtask

  task automatic test_contention(input int tgt, input int npulse, input int exp_own [4],
                                 input int exp_t [4]);
    int own_q[$];
    int t_q[$];
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 8'h30;
    for (int n = 0; n < 60 && own_q.size() < npulse; n++) begin
      @(negedge clk);
      if (cpu_ready_w[tgt]) begin own_q.push_back(0); t_q.push_back(n); end
      else if (aux_ready_w[tgt]) begin own_q.push_back(1); t_q.push_back(n); end
    end
    chk("pulse_count", tgt, 32'(own_q.size()), 32'(npulse));
    for (int k = 0; k < own_q.size() && k < 4; k++) begin
      chk("win_order", tgt, 32'(own_q[k]), 32'(exp_own[k]));
      chk("ready_cycle", tgt, 32'(t_q[k]), 32'(exp_t[k]));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int nready;
    reset_cycle = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = 8'h00; aux_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_cycle = 1'b0;

    // cpu read of 0x10 (holds 0x5A)
    access_on(0, 1'b0, 1'b0, 8'h10, 8'h00, lat);
    chk("cpu_rd_latency", 0, 32'(lat), 32'd4);
    chk("cpu_rd_data", 0, 32'(cpu_rdata_w[0]), 32'h5A);
    wait_idle();

    // aux write 0x20 <= 0xC3, then cpu reads it back
    access_on(0, 1'b1, 1'b1, 8'h20, 8'hC3, lat);
    chk("aux_wr_latency", 0, 32'(lat), 32'd4);
    wait_idle();
    access_on(0, 1'b0, 1'b0, 8'h20, 8'h00, lat);
    chk("cpu_rd_after_wr_latency", 0, 32'(lat), 32'd4);
    chk("cpu_rd_after_wr_data", 0, 32'(cpu_rdata_w[0]), 32'hC3);
    chk("aux_rdata_untouched", 0, 32'(aux_rdata_w[0]), 32'h00);
    wait_idle();

    // round-robin contention straight after reset
    pulse_reset();
    test_contention(0, 4, '{0, 1, 0, 1}, '{4, 9, 14, 19});
    cpu_req = 1'b0; aux_req = 1'b0;
    wait_idle();

    // cpu priority: aux starved until cpu_req stays low
    test_contention(1, 3, '{0, 0, 0, 0}, '{4, 9, 14, 0});
    cpu_req = 1'b0;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (aux_ready_w[1]) begin lat = n; break; end
    end
    chk("aux_after_starve_latency", 1, 32'(lat), 32'd4);
    @(posedge clk); #1;
    aux_req = 1'b0;
    wait_idle();

    // reset in the first ACCESS cycle of a cpu read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    @(posedge clk); #1;
    chk("ram_en_before_reset", 0, 32'(ram_en_w[0]), 32'd1);
    reset_cycle = 1'b1;
    cpu_req = 1'b0;
    #1;
    chk("ram_en_async_drop", 0, 32'(ram_en_w[0]), 32'd0);
    chk("grant_async_drop", 0, 32'(grant_w[0]), 32'd0);
    chk("busy_async_drop", 0, 32'(busy_w[0]), 32'd0);
    @(posedge clk); #1;
    reset_cycle = 1'b0;
    nready = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (cpu_ready_w[0]) nready++;
    end
    chk("no_ready_after_reset", 0, 32'(nready), 32'd0);
    @(posedge clk); #1;
    wait_idle();
    access_on(0, 1'b0, 1'b0, 8'h10, 8'h00, lat);
    chk("fresh_rd_latency", 0, 32'(lat), 32'd4);
    chk("fresh_rd_data", 0, 32'(cpu_rdata_w[0]), 32'h5A);
    wait_idle();

    // latency sweep: L=1 and L=15
    access_on(2, 1'b0, 1'b0, 8'h44, 8'h00, lat);
    chk("lat1_latency", 2, 32'(lat), 32'd3);
    chk("lat1_data", 2, 32'(cpu_rdata_w[2]), 32'h78);
    wait_idle();
    access_on(3, 1'b1, 1'b0, 8'h55, 8'h00, lat);
    chk("lat15_latency", 3, 32'(lat), 32'd17);
    chk("lat15_data", 3, 32'(aux_rdata_w[3]), 32'h69);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single 8-bit RAM port between two requesters: port 0 is the CPU (instruction/immediate fetch, stack and MOV data) and port 1 is the auxiliary master (program loader / I/O DMA). It serialises accesses, sequences the RAM's fixed read latency, and returns a one-cycle ready pulse that the CPU controller uses as its bus_ready. It sits between the CPU control/datapath and the RAM model.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data width
RAM_LATENCY, 2, cycles from ram_en to ram_rdata valid; legal range 1..15
CPU_PRIORITY, 0, 0 = round-robin between ports; 1 = port 0 always wins ties

Ports:
clk  in  1  clock, rising edge
reset_cycle  in  1  reset, asynchronous, active-high
cpu_req  in  1  port 0 access request (level)
cpu_we  in  1  port 0 write enable (1 = write)
cpu_addr  in  ADDR_W  port 0 address
cpu_wdata  in  DATA_W  port 0 write data
cpu_ready  out  1  port 0 completion pulse
cpu_rdata  out  DATA_W  port 0 read data, valid with cpu_ready
aux_req  in  1  port 1 access request (level)
aux_we  in  1  port 1 write enable
aux_addr  in  ADDR_W  port 1 address
aux_wdata  in  DATA_W  port 1 write data
aux_ready  out  1  port 1 completion pulse
aux_rdata  out  DATA_W  port 1 read data, valid with aux_ready
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
grant  out  2  one-hot owner: bit0 = cpu, bit1 = aux; 00 when idle
busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered or decoded from registered state. On reset: state IDLE, grant 00, busy 0, ram_en/ram_we 0, ram_addr/ram_wdata 0, cpu_ready/aux_ready 0, cpu_rdata/aux_rdata 0, last_grant = aux, latency counter 0.
- Requester protocol: a requester holds req, we, addr and wdata stable until its ready pulse. It must drop req in the cycle after ready unless it issues a new access. A req still high in the cycle after ready is treated as a new access.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: arbitrates on requests sampled this cycle.
  - Only one request pending: that port wins.
  - Both pending with CPU_PRIORITY=1: cpu wins.
  - Both pending with CPU_PRIORITY=0: the port that is not last_grant wins.
  - On a win, at the edge: latch the winner's we/addr/wdata, set grant one-hot, update last_grant, clear the counter, go to ACCESS.
- ACCESS: lasts exactly RAM_LATENCY cycles.
  - ram_en = 1 and ram_we = latched we in the first ACCESS cycle only.
  - ram_addr/ram_wdata hold the latched values throughout ACCESS and CAPTURE.
  - The counter increments each cycle. Leave for CAPTURE when counter == RAM_LATENCY-1.
- CAPTURE: one cycle. For reads, ram_rdata is valid; register it into the granted port's rdata at the edge. Writes leave rdata unchanged. Go to RESP.
- RESP: one cycle. The granted port's ready = 1 and its rdata is valid. The other port's ready = 0. Then go to IDLE and set grant to 00.
- Timing: request sampled in IDLE at cycle 0 → ram_en in cycle 1 → ready in cycle RAM_LATENCY+2. With the default this is cycle 4. Reads and writes use identical timing.
- Throughput: one access per RAM_LATENCY+3 cycles. There is no back-to-back bypass; IDLE is always visited.
- rdata registers hold their value until that port's next completed read.
- A request arriving while busy waits and is evaluated in the next IDLE cycle. A req that drops while busy has no effect on the transaction in flight.
- The same requester winning repeatedly is allowed when the other port is not requesting.
- Reset asserted mid-transaction: immediate return to reset values. No ready pulse is produced and ram_en drops asynchronously. The in-flight access is lost; the requester reissues after reset.
- ready pulses are mutually exclusive and never last more than one cycle.

Test Plan:
- cpu-only read, RAM_LATENCY=2, addr 0x10 holding 0x5A: cpu_req in cycle 0 → ram_en=1 with ram_addr=0x10 in cycle 1 only; cpu_ready=1 and cpu_rdata=0x5A in cycle 4; grant=01 in cycles 1–4.
- aux write addr 0x20 data 0xC3, then cpu read of 0x20: ram_we=1 only in the aux ACCESS first cycle; aux_ready in cycle 4; the cpu read returns 0xC3; aux_rdata stays 0x00.
- Simultaneous cpu_req+aux_req held continuously, CPU_PRIORITY=0, after reset: grant order cpu, aux, cpu, aux; ready pulses 5 cycles apart.
- Same stimulus with CPU_PRIORITY=1 and cpu re-requesting immediately after every ready: cpu wins every time and aux is starved; aux is served once cpu_req stays low.
- reset_cycle pulsed during ACCESS of a cpu read: ram_en, grant and busy go 0 immediately; no cpu_ready follows. A fresh read after reset completes in 4 cycles.
- RAM_LATENCY=1 and RAM_LATENCY=15 sweeps: ready arrives at cycle 3 and cycle 17 respectively, with correct read data.
